// File: rtl/seg_scan_decoder.sv
// Display monitor: samples a 4-digit multiplexed 7-segment bus, captures settled slots and rebuilds MM:SS digits.
// Optional SEG_SYNC_EN adds a 2-flop synchronizer on anode/seg ahead of the sample register.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 400_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] anode,
  input  logic [7:0] seg,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       frame_valid,
  output logic       decode_err,
  output logic       stale
);

  localparam int unsigned SAMP_W = 12;
  localparam int unsigned STAB_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_PRE = STAB_W'(STABLE_CYCLES - 2);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_PRE   = TO_W'(TIMEOUT_CYCLES - 2);

  logic [SAMP_W-1:0] raw;
  logic [SAMP_W-1:0] samp;
  logic [SAMP_W-1:0] samp_q;
  logic [STAB_W-1:0] stab_cnt;
  logic              cap;
  logic [3:0]        cap_anode;
  logic [6:0]        cap_pat;
  logic [3:0]        seen;
  logic [TO_W-1:0]   to_cnt;

  logic              cap_c;
  logic [3:0]        dec_c;
  logic              pat_err_c;
  logic [3:0]        slot_bit_c;
  logic              one_hot_c;
  logic              hit_c;
  logic [3:0]        seen_nx_c;

  assign raw = {anode, seg};

`ifdef SEG_SYNC_EN
  logic [SAMP_W-1:0] sync1;
  logic [SAMP_W-1:0] sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      samp  <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      samp  <= sync2;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) samp <= '1;
    else     samp <= raw;
  end
`endif

  // Stability tracking: one capture per stable window, then saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q   <= '1;
      stab_cnt <= '0;
    end else begin
      samp_q <= samp;
      if (samp != samp_q)          stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + STAB_W'(1);
    end
  end

  assign cap_c = (samp == samp_q) && (stab_cnt == STAB_PRE);

  // Capture is registered together with the settled sample it refers to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap       <= 1'b0;
      cap_anode <= 4'hF;
      cap_pat   <= 7'h7F;
    end else begin
      cap       <= cap_c;
      cap_anode <= samp_q[11:8];
      cap_pat   <= samp_q[6:0];
    end
  end

  function automatic logic [3:0] decode(input logic [6:0] pat);
    logic [3:0] d;
    case (pat)
      7'h40:   d = 4'd0;
      7'h79:   d = 4'd1;
      7'h24:   d = 4'd2;
      7'h30:   d = 4'd3;
      7'h19:   d = 4'd4;
      7'h12:   d = 4'd5;
      7'h02:   d = 4'd6;
      7'h78:   d = 4'd7;
      7'h00:   d = 4'd8;
      7'h10:   d = 4'd9;
      7'h7F:   d = 4'hF;
      default: d = 4'hE;
    endcase
    return d;
  endfunction

  always_comb begin
    slot_bit_c = 4'b0000;
    case (cap_anode)
      4'b0111: slot_bit_c = 4'b1000;
      4'b1011: slot_bit_c = 4'b0100;
      4'b1101: slot_bit_c = 4'b0010;
      4'b1110: slot_bit_c = 4'b0001;
      default: slot_bit_c = 4'b0000;
    endcase
    dec_c     = decode(cap_pat);
    pat_err_c = (dec_c == 4'hE);
    one_hot_c = |slot_bit_c;
    // A blanked bus (all anodes off) is not display activity.
    hit_c     = cap && (cap_anode != 4'hF);
    seen_nx_c = seen | slot_bit_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_tens  <= 4'hF;
      min_units <= 4'hF;
      sec_tens  <= 4'hF;
      sec_units <= 4'hF;
    end else if (hit_c) begin
      if (slot_bit_c[3]) min_tens  <= dec_c;
      if (slot_bit_c[2]) min_units <= dec_c;
      if (slot_bit_c[1]) sec_tens  <= dec_c;
      if (slot_bit_c[0]) sec_units <= dec_c;
    end
  end

  // Frame assembly and timeout; a capture takes priority over timeout expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen        <= '0;
      to_cnt      <= '0;
      stale       <= 1'b1;
      frame_valid <= 1'b0;
      decode_err  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      decode_err  <= 1'b0;
      if (hit_c) begin
        to_cnt <= '0;
        stale  <= 1'b0;
        if (one_hot_c) begin
          decode_err <= pat_err_c;
          if (seen_nx_c == 4'hF) begin
            seen        <= '0;
            frame_valid <= 1'b1;
          end else begin
            seen <= seen_nx_c;
          end
        end else begin
          decode_err <= 1'b1;
        end
      end else if (to_cnt == TO_PRE) begin
        to_cnt <= TO_MAX;
        stale  <= 1'b1;
        seen   <= '0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

endmodule
